// File: rtl/serial_asm_pkg.sv
// ============================================================================
// Module   : serial_asm_pkg
// Brief    : Shared constants, frame sizing and byte type for the serial
//            byte assembler. Frame length grows by one when PARITY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_asm_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 2;

`ifdef PARITY_CHECK_EN
    localparam int c_parity_bits = 1;
`else
    localparam int c_parity_bits = 0;
`endif

    localparam int c_frame_len_def = WIDTH_DEF + c_parity_bits;

    typedef logic [WIDTH_DEF-1:0] byte_t;

    function automatic int cnt_width(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

    localparam int c_cnt_w_def = cnt_width(c_frame_len_def);

endpackage

`default_nettype wire

// File: rtl/sync_fifo_small.sv
// ============================================================================
// Module   : sync_fifo_small
// Brief    : DEPTH-entry circular holding buffer with a registered head word.
//            A pop frees its slot in time for a push on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_small
    import serial_asm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_occ_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_occ_w-1:0] r_occ;
    logic [WIDTH-1:0]   r_head;

    logic               w_push_ok;
    logic               w_pop_ok;
    logic [c_ptr_w-1:0] w_rd_ptr_nxt;

    assign full         = (r_occ == c_occ_w'(DEPTH));
    assign empty        = (r_occ == '0);
    assign w_pop_ok     = pop & ~empty;
    assign w_push_ok    = push & (~full | w_pop_ok);
    assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;
    assign head_data    = r_head;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // r_head is a copy of the head slot so the output holds its last value
    // once the buffer drains instead of exposing a stale slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_head   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (w_pop_ok && (r_occ > c_occ_w'(1))) begin
                r_head <= r_mem[w_rd_ptr_nxt];
            end else if (w_push_ok && (empty || (w_pop_ok && (r_occ == c_occ_w'(1))))) begin
                r_head <= push_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_byte_assembler.sv
// ============================================================================
// Module   : serial_byte_assembler
// Brief    : Assembles an LSB-first serial stream into bytes, buffers them and
//            offers them on valid/ready. Optional macro: PARITY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_byte_assembler
    import serial_asm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             byte_ready,
    input  logic             overrun_clr,
    output logic             byte_valid,
    output logic [WIDTH-1:0] byte_data,
    output logic             load,
    output logic             overrun,
    output logic             parity_err
);

    localparam int c_frame_len = WIDTH + c_parity_bits;
    localparam int c_cnt_w     = cnt_width(c_frame_len);
    localparam int c_sh_w      = c_frame_len - 1;

    // Only the bits before the final one are stored; the final bit is taken
    // straight from serial_in when the frame completes.
    logic [c_sh_w-1:0]  r_shreg;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_overrun;

    logic               w_last;
    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
    logic [WIDTH-1:0]   w_frame_byte;

    assign w_last = serial_valid & (r_cnt == c_cnt_w'(c_frame_len - 1));

`ifdef PARITY_CHECK_EN
    logic r_parity_err;
    logic w_par_ok;

    assign w_frame_byte = r_shreg;
    assign w_par_ok     = ~(^{serial_in, r_shreg});
    assign w_push       = w_last & w_par_ok;
    assign parity_err   = r_parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_last & ~w_par_ok;
        end
    end
`else
    assign w_frame_byte = {serial_in, r_shreg};
    assign w_push       = w_last;
    assign parity_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (serial_valid) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_shreg <= {serial_in, r_shreg[c_sh_w-1:1]};
            end
        end
    end

    // A same-cycle pop makes room, so only a push with no pop is dropped.
    assign w_drop = w_push & w_full & ~load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    sync_fifo_small #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_frame_byte),
        .pop       (load),
        .full      (w_full),
        .empty     (w_empty),
        .head_data (byte_data)
    );

    assign byte_valid = ~w_empty;
    assign load       = byte_valid & byte_ready;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire
